// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller slice.
package hazard_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MEM_WAIT = 2'd1
  } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard inputs from the datapath and pipeline-register controls back to it.
interface pipeline_hazard_controller_if;

  logic [hazard_pkg::REG_IDX_W-1:0] id_rs_i;
  logic [hazard_pkg::REG_IDX_W-1:0] id_rt_i;
  logic                             id_uses_rt_i;
  logic                             idex_mem_read_i;
  logic [hazard_pkg::REG_IDX_W-1:0] idex_write_register_i;
  logic                             ex_branch_taken_i;
  logic                             ex_jmp_i;
  // Memory handshake: dmem_req_i marks a MEM-stage access; the access
  // completes in the cycle dmem_ready_i is high. Until then the pipe freezes.
  logic                             dmem_req_i;
  logic                             dmem_ready_i;

  logic pc_enable_o;
  logic ifid_enable_o;
  logic idex_enable_o;
  logic exmem_enable_o;
  logic memwb_enable_o;
  logic ifid_flush_o;
  logic idex_flush_o;

  // Controller side.
  modport master (
    input  id_rs_i, id_rt_i, id_uses_rt_i, idex_mem_read_i,
           idex_write_register_i, ex_branch_taken_i, ex_jmp_i,
           dmem_req_i, dmem_ready_i,
    output pc_enable_o, ifid_enable_o, idex_enable_o, exmem_enable_o,
           memwb_enable_o, ifid_flush_o, idex_flush_o
  );

  // Datapath side.
  modport slave (
    output id_rs_i, id_rt_i, id_uses_rt_i, idex_mem_read_i,
           idex_write_register_i, ex_branch_taken_i, ex_jmp_i,
           dmem_req_i, dmem_ready_i,
    input  pc_enable_o, ifid_enable_o, idex_enable_o, exmem_enable_o,
           memwb_enable_o, ifid_flush_o, idex_flush_o
  );

endinterface

// File: rtl/hazard_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_o <= '0;
    end else if (inc_i && (count_o != '1)) begin
      count_o <= count_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Load-use / control-flush / memory-freeze sequencer for the 5-stage pipeline.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int COUNT_WIDTH = 16,
  parameter int MAX_WAIT    = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  pipeline_hazard_controller_if.master hz,
  output logic [COUNT_WIDTH-1:0]       stall_count_o,
  output logic [COUNT_WIDTH-1:0]       flush_count_o,
  output logic                         timeout_o,
  output logic [1:0]                   state_o
);

  localparam logic [7:0] MAX_WAIT_8 = 8'(MAX_WAIT);

  hz_state_t  state_q;
  hz_state_t  state_d;
  logic [7:0] wait_cnt_q;
  logic [7:0] wait_cnt_inc;
  logic       timeout_q;

  logic       freeze;
  logic       ctrl_flush;
  logic       load_use;
  logic       stall_inc;
  logic       flush_inc;
  logic [4:0] en;        // {pc, ifid, idex, exmem, memwb}
  logic       ifid_fl;
  logic       idex_fl;

  assign ctrl_flush = hz.ex_branch_taken_i | hz.ex_jmp_i;

  assign load_use = hz.idex_mem_read_i &&
                    (hz.idex_write_register_i != '0) &&
                    ((hz.idex_write_register_i == hz.id_rs_i) ||
                     (hz.id_uses_rt_i && (hz.idex_write_register_i == hz.id_rt_i)));

  always_comb begin
    freeze  = 1'b0;
    state_d = HZ_RUN;
    en      = 5'b11111;
    ifid_fl = 1'b0;
    idex_fl = 1'b0;

    // Illegal encodings behave like RUN and therefore fall back to it.
    case (state_q)
      HZ_MEM_WAIT: freeze = !hz.dmem_ready_i;
      default:     freeze = hz.dmem_req_i && !hz.dmem_ready_i;
    endcase

    if (freeze) begin
      state_d = HZ_MEM_WAIT;
    end

    if (freeze) begin
      en = 5'b00000;
    end else if (ctrl_flush) begin
      ifid_fl = 1'b1;
      idex_fl = 1'b1;
    end else if (load_use) begin
      en      = 5'b00111;
      idex_fl = 1'b1;
    end
  end

  assign stall_inc = freeze | (!ctrl_flush & load_use);
  assign flush_inc = !freeze & ctrl_flush;

  // Reset forces every control low without waiting for a clock.
  assign hz.pc_enable_o    = reset & en[4];
  assign hz.ifid_enable_o  = reset & en[3];
  assign hz.idex_enable_o  = reset & en[2];
  assign hz.exmem_enable_o = reset & en[1];
  assign hz.memwb_enable_o = reset & en[0];
  assign hz.ifid_flush_o   = reset & ifid_fl;
  assign hz.idex_flush_o   = reset & idex_fl;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HZ_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign wait_cnt_inc = (wait_cnt_q == 8'hFF) ? 8'hFF : (wait_cnt_q + 8'd1);

  // The wait keeps going after a timeout; the flag only reports it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else if (state_q == HZ_MEM_WAIT) begin
      wait_cnt_q <= wait_cnt_inc;
      if (wait_cnt_inc >= MAX_WAIT_8) begin
        timeout_q <= 1'b1;
      end
    end else begin
      wait_cnt_q <= '0;
    end
  end

  hazard_sat_counter #(.WIDTH(COUNT_WIDTH)) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (stall_inc),
    .count_o (stall_count_o)
  );

  hazard_sat_counter #(.WIDTH(COUNT_WIDTH)) u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (flush_inc),
    .count_o (flush_count_o)
  );

  assign timeout_o = timeout_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller with a cycle-level reference model.
module tb_pipeline_hazard_controller;
  import hazard_pkg::*;

  localparam int CW   = 3;
  localparam int MW   = 3;
  localparam int W    = 10 + 2 * CW;
  localparam int CMAX = (1 << CW) - 1;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [CW-1:0] stall_count;
  logic [CW-1:0] flush_count;
  logic          timeout;
  logic [1:0]    state;

  pipeline_hazard_controller_if hz ();

  pipeline_hazard_controller #(.COUNT_WIDTH(CW), .MAX_WAIT(MW)) dut (
    .clk           (clk),
    .reset         (reset),
    .hz            (hz),
    .stall_count_o (stall_count),
    .flush_count_o (flush_count),
    .timeout_o     (timeout),
    .state_o       (state)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  string phase = "reset";

  // Reference model: waiting flag, cycles spent waiting, sticky timeout, event totals
  bit m_wait;
  bit m_to;
  int m_wcnt;
  int m_stall;
  int m_flush;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] want;
      logic [W-1:0] got;
      want = exp_q.pop_front();
      got  = {hz.pc_enable_o, hz.ifid_enable_o, hz.idex_enable_o,
              hz.exmem_enable_o, hz.memwb_enable_o,
              hz.ifid_flush_o, hz.idex_flush_o,
              state, timeout, stall_count, flush_count};
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL %s @%0t: got en=%b fl=%b st=%b to=%b stall=%0d flush=%0d, want en=%b fl=%b st=%b to=%b stall=%0d flush=%0d",
                 phase, $time,
                 got[W-1 -: 5], got[W-6 -: 2], got[W-8 -: 2], got[2*CW],
                 got[2*CW-1 -: CW], got[CW-1:0],
                 want[W-1 -: 5], want[W-6 -: 2], want[W-8 -: 2], want[2*CW],
                 want[2*CW-1 -: CW], want[CW-1:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Driver: apply one cycle of inputs, predict the response, advance the model
  task automatic drive(input logic br, input logic jmp, input logic mr,
                       input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic req, input logic rdy);
    bit            frz;
    bit            ctl;
    bit            lu;
    logic [4:0]    en;
    logic [1:0]    fl;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
    reset                    = 1'b1;
    hz.ex_branch_taken_i     = br;
    hz.ex_jmp_i              = jmp;
    hz.idex_mem_read_i       = mr;
    hz.idex_write_register_i = wr;
    hz.id_rs_i               = rs;
    hz.id_rt_i               = rt;
    hz.id_uses_rt_i          = urt;
    hz.dmem_req_i            = req;
    hz.dmem_ready_i          = rdy;

    frz = m_wait ? !rdy : (req && !rdy);
    ctl = br || jmp;
    lu  = mr && (wr != 0) && ((wr == rs) || (urt && (wr == rt)));
    if (frz)      begin en = 5'b00000; fl = 2'b00; end
    else if (ctl) begin en = 5'b11111; fl = 2'b11; end
    else if (lu)  begin en = 5'b00111; fl = 2'b01; end
    else          begin en = 5'b11111; fl = 2'b00; end
    sc = m_stall[CW-1:0];
    fc = m_flush[CW-1:0];
    exp_q.push_back({en, fl, 1'b0, m_wait, m_to, sc, fc});

    if (frz || (lu && !ctl)) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
    if (ctl && !frz)         m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
    if (m_wait) begin
      m_wcnt = (m_wcnt < 255) ? m_wcnt + 1 : 255;
      if (m_wcnt >= MW) m_to = 1'b1;
    end else begin
      m_wcnt = 0;
    end
    m_wait = frz;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  // Reset asserted off the clock edge; everything reads zero right away
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      reset = 1'b0;
      exp_q.push_back('0);
      m_wait  = 1'b0;
      m_to    = 1'b0;
      m_wcnt  = 0;
      m_stall = 0;
      m_flush = 0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset                    = 1'b0;
    hz.ex_branch_taken_i     = 1'b0;
    hz.ex_jmp_i              = 1'b0;
    hz.idex_mem_read_i       = 1'b0;
    hz.idex_write_register_i = '0;
    hz.id_rs_i               = '0;
    hz.id_rt_i               = '0;
    hz.id_uses_rt_i          = 1'b0;
    hz.dmem_req_i            = 1'b0;
    hz.dmem_ready_i          = 1'b1;
    m_wait = 1'b0; m_to = 1'b0; m_wcnt = 0; m_stall = 0; m_flush = 0;
    @(posedge clk);
    #1;
    do_reset(2);

    phase = "load_use";
    drive(1'b0, 1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b1);
    idle();

    phase = "branch_flush";
    do_reset(1);
    drive(1'b1, 1'b0, 1'b1, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1);
    idle();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle();

    phase = "mem_wait";
    do_reset(1);
    repeat (4) drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    idle();

    phase = "freeze_vs_ctrl";
    do_reset(1);
    repeat (2) drive(1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1);
    repeat (2) drive(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1);
    idle();

    phase = "timeout";
    do_reset(1);
    repeat (10) drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    repeat (3) idle();

    phase = "saturation";
    do_reset(1);
    repeat (10) drive(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    repeat (10) drive(1'b0, 1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1);

    phase = "async_reset";
    repeat (3) drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    do_reset(1);
    drive(1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1);
    repeat (2) idle();

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1);
      end else begin
        drive(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 11) == 0),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 3) != 0));
      end
    end

    phase = "drain";
    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
